// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, fetches from a
// variable-latency instruction memory over a req/ready handshake and
// feeds the IF/ID register. A one-entry skid buffer catches a fetch that
// completes while decode is stalled.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned
// redirect targets (sticky misalign_o, fetch halts until reset).
// Without it the low target bits are dropped and misalign_o is 0.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ready_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               ifid_valid_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [ADDR_W-1:0]  ifid_pc_o,
    output logic [ADDR_W-1:0]  ifid_pc_next_o,
    output logic               misalign_o
);

    // PC_STEP is a power of two, so STEP-1 masks the sub-step address bits.
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = STEP - ADDR_W'(1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,  // request outstanding at pc
        S_HOLD  = 2'd1,  // skid full, waiting for stall release
        S_HALT  = 2'd2   // trapped, only reset leaves
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_inc;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic [ADDR_W-1:0]  ifid_pc_next_q, ifid_pc_next_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic               misalign_q, misalign_d;
`endif

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_inc = pc_q + STEP;

    // Next-state and datapath: redirect beats response/stall handling.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        skid_instr_d   = skid_instr_q;
        skid_pc_d      = skid_pc_q;
        ifid_valid_d   = ifid_valid_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_pc_next_d = ifid_pc_next_q;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d     = misalign_q;
`endif

        if (redirect_i && (state_q != S_HALT)) begin
            // Flush regardless of stall; any response this cycle is dropped.
            ifid_valid_d = 1'b0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
`ifdef FETCH_ALIGN_CHECK_EN
            if ((redirect_pc_i & ALIGN_MASK) != '0) begin
                misalign_d = 1'b1;
                state_d    = S_HALT;
            end else begin
                pc_d    = redirect_pc_i;
                state_d = S_FETCH;
            end
`else
            pc_d    = redirect_pc_i & ~ALIGN_MASK;
            state_d = S_FETCH;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready_i) begin
                        pc_d = pc_inc;
                        if (stall_i) begin
                            // Decode can't take it: park it in the skid.
                            skid_instr_d = imem_data_i;
                            skid_pc_d    = pc_q;
                            state_d      = S_HOLD;
                        end else begin
                            ifid_valid_d   = 1'b1;
                            ifid_instr_d   = imem_data_i;
                            ifid_pc_d      = pc_q;
                            ifid_pc_next_d = pc_inc;
                        end
                    end else if (!stall_i) begin
                        // Memory still busy: insert a bubble.
                        ifid_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        ifid_valid_d   = 1'b1;
                        ifid_instr_d   = skid_instr_q;
                        ifid_pc_d      = skid_pc_q;
                        ifid_pc_next_d = skid_pc_q + STEP;
                        state_d        = S_FETCH;
                    end
                end
                S_HALT: begin
                    ifid_valid_d = 1'b0;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // PC, skid and IF/ID registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q           <= RESET_PC;
            skid_instr_q   <= '0;
            skid_pc_q      <= '0;
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= '0;
            ifid_pc_q      <= '0;
            ifid_pc_next_q <= '0;
        end else begin
            pc_q           <= pc_d;
            skid_instr_q   <= skid_instr_d;
            skid_pc_q      <= skid_pc_d;
            ifid_valid_q   <= ifid_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_pc_next_q <= ifid_pc_next_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misalign flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    // Request is quiet during reset so memory never sees a stale PC.
    assign imem_req_o     = (state_q == S_FETCH) & ~rst_i;
    assign imem_addr_o    = pc_q;
    assign ifid_valid_o   = ifid_valid_q;
    assign ifid_instr_o   = ifid_instr_q;
    assign ifid_pc_o      = ifid_pc_q;
    assign ifid_pc_next_o = ifid_pc_next_q;

endmodule
